// File: rtl/cmd_word_decoder.sv
// Command word decoder: assembles big-endian 32-bit words from a byte stream and applies OUT commands.
// Optional inter-byte timeout is enabled by defining CMD_DEC_TIMEOUT_EN.
module cmd_word_decoder #(
   parameter int unsigned COUNT_W        = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         byte_data,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic [4:0]         out_val,
   output logic               out_stb,
   output logic               err_stb,
   output logic [1:0]         err_code,
   output logic [COUNT_W-1:0] cmd_count
);

   localparam logic [3:0] CMD_ID_OUT   = 4'b0001;
   localparam logic [1:0] ERR_UNKNOWN  = 2'b01;
   localparam logic [1:0] ERR_RESERVED = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_B1,
      S_B2,
      S_B3,
      S_EXEC
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] word;
   logic        accept;
   logic        tmo;
   logic        do_out;
   logic        do_err;
   logic [1:0]  err_next;

   assign byte_ready = (state != S_EXEC);
   assign accept     = byte_valid && byte_ready;

`ifdef CMD_DEC_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

   logic [IDLE_W-1:0] idle_cnt;
   logic              in_word;

   assign in_word = (state == S_B1) || (state == S_B2) || (state == S_B3);
   // An accepted byte in the terminal-count cycle suppresses the timeout.
   assign tmo     = in_word && !accept && (idle_cnt == IDLE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (!in_word || accept || tmo) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      do_out     = 1'b0;
      do_err     = 1'b0;
      err_next   = 2'b00;
      case (state)
         S_IDLE: if (accept) next_state = S_B1;
         S_B1: begin
            if (accept)   next_state = S_B2;
            else if (tmo) next_state = S_IDLE;
         end
         S_B2: begin
            if (accept)   next_state = S_B3;
            else if (tmo) next_state = S_IDLE;
         end
         S_B3: begin
            if (accept)   next_state = S_EXEC;
            else if (tmo) next_state = S_IDLE;
         end
         S_EXEC: begin
            next_state = S_IDLE;
            if (word[31:28] != CMD_ID_OUT) begin
               do_err   = 1'b1;
               err_next = ERR_UNKNOWN;
            end else if (|word[27:5]) begin
               do_err   = 1'b1;
               err_next = ERR_RESERVED;
            end else begin
               do_out = 1'b1;
            end
         end
         default: next_state = S_IDLE;
      endcase
      if (tmo) begin
         do_err   = 1'b1;
         err_next = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word      <= '0;
         out_val   <= '0;
         out_stb   <= 1'b0;
         err_stb   <= 1'b0;
         err_code  <= '0;
         cmd_count <= '0;
      end else begin
         out_stb <= do_out;
         err_stb <= do_err;
         if (do_err) begin
            err_code <= err_next;
         end
         if (do_out) begin
            out_val   <= word[4:0];
            cmd_count <= cmd_count + COUNT_W'(1);
         end
         if (accept) begin
            word <= (state == S_IDLE) ? {24'h000000, byte_data} : {word[23:0], byte_data};
         end else if (tmo) begin
            word <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cmd_word_decoder.sv
// Bench for cmd_word_decoder: table-driven word vectors with a strobe scoreboard, plus
// back-to-back, inter-byte gap/timeout and mid-word reset sequences.
module tb_cmd_word_decoder;

   localparam int unsigned COUNT_W = 16;
   localparam int unsigned TIMEOUT = 1000;

   logic               clk;
   logic               rst_n;
   logic [7:0]         byte_data;
   logic               byte_valid;
   logic               byte_ready;
   logic [4:0]         out_val;
   logic               out_stb;
   logic               err_stb;
   logic [1:0]         err_code;
   logic [COUNT_W-1:0] cmd_count;

   cmd_word_decoder #(
      .COUNT_W        (COUNT_W),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .out_val    (out_val),
      .out_stb    (out_stb),
      .err_stb    (err_stb),
      .err_code   (err_code),
      .cmd_count  (cmd_count)
   );

   typedef struct {
      logic [31:0] w;
      logic        is_err;
      logic [1:0]  code;
      logic [4:0]  val;
   } vec_t;

   typedef struct {
      logic       is_err;
      logic [1:0] code;
      logic [4:0] val;
      int         count;
   } exp_t;

   exp_t        sb[$];
   vec_t        tbl[11];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [4:0]  m_val    = '0;
   int          m_count  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic is_err, input logic [1:0] code, input logic [4:0] val);
      exp_t e;
      if (!is_err) begin
         m_val = val;
         m_count++;
      end
      e.is_err = is_err;
      e.code   = code;
      e.val    = m_val;
      e.count  = m_count % (1 << COUNT_W);
      sb.push_back(e);
   endtask

   // Scoreboard: every strobe consumes one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (out_stb || err_stb)) begin
         check("stb_exclusive", {31'd0, out_stb & err_stb}, 32'd0);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got out_stb=%0b err_stb=%0b expected no strobe at %0t",
                     out_stb, err_stb, $time);
         end else begin
            e = sb.pop_front();
            check("sb_kind_err", {31'd0, err_stb}, {31'd0, e.is_err});
            if (e.is_err) check("sb_err_code", {30'd0, err_code}, {30'd0, e.code});
            check("sb_out_val", {27'd0, out_val}, {27'd0, e.val});
            check("sb_cmd_count", {16'd0, cmd_count}, e.count);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output int acc);
      int n;
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_wait: got byte_ready=0 expected 1 within 20 cycles at %0t", $time);
      end
      acc = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      int acc;
      send_byte(w[31:24], acc);
      send_byte(w[23:16], acc);
      send_byte(w[15:8], acc);
      send_byte(w[7:0], acc);
      byte_valid = 1'b0;
      @(negedge clk);
      check("lat_exec_no_stb", {31'd0, out_stb | err_stb}, 32'd0);
      check("ready_low_exec", {31'd0, byte_ready}, 32'd0);
      @(negedge clk);
      check("lat_stb_high", {31'd0, out_stb | err_stb}, 32'd1);
      @(negedge clk);
      check("stb_one_cycle", {31'd0, out_stb | err_stb}, 32'd0);
   endtask

   initial begin
      int acc[8];
      int a;
      int n;

      tbl[0]  = '{32'h1000_0015, 1'b0, 2'b00, 5'h15};
      tbl[1]  = '{32'h2000_0003, 1'b1, 2'b01, 5'h00};
      tbl[2]  = '{32'h1000_0103, 1'b1, 2'b10, 5'h00};
      tbl[3]  = '{32'h1000_001F, 1'b0, 2'b00, 5'h1F};
      tbl[4]  = '{32'h1000_001F, 1'b0, 2'b00, 5'h1F};
      tbl[5]  = '{32'hF000_0000, 1'b1, 2'b01, 5'h00};
      tbl[6]  = '{32'h0000_0001, 1'b1, 2'b01, 5'h00};
      tbl[7]  = '{32'h1800_0000, 1'b1, 2'b10, 5'h00};
      tbl[8]  = '{32'h1000_0020, 1'b1, 2'b10, 5'h00};
      tbl[9]  = '{32'h30FF_FFFF, 1'b1, 2'b01, 5'h00};
      tbl[10] = '{32'h1000_0000, 1'b0, 2'b00, 5'h00};

      rst_n      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = '0;
      #12;
      check("rst_out_val", {27'd0, out_val}, 32'd0);
      check("rst_out_stb", {31'd0, out_stb}, 32'd0);
      check("rst_err_stb", {31'd0, err_stb}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_cmd_count", {16'd0, cmd_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd1);

      for (int unsigned i = 0; i < 11; i++) begin
         push_exp(tbl[i].is_err, tbl[i].code, tbl[i].val);
         send_word(tbl[i].w);
      end

      // Back-to-back: byte_valid held high across two words.
      push_exp(1'b0, 2'b00, 5'h01);
      push_exp(1'b0, 2'b00, 5'h02);
      send_byte(8'h10, acc[0]);
      send_byte(8'h00, acc[1]);
      send_byte(8'h00, acc[2]);
      send_byte(8'h01, acc[3]);
      send_byte(8'h10, acc[4]);
      send_byte(8'h00, acc[5]);
      send_byte(8'h00, acc[6]);
      send_byte(8'h02, acc[7]);
      byte_valid = 1'b0;
      check("b2b_gap_after_word", acc[4] - acc[3], 32'd2);
      check("b2b_total_span", acc[7] - acc[0], 32'd8);
      repeat (4) @(negedge clk);
      check("b2b_cmd_count", {16'd0, cmd_count}, m_count);

`ifdef CMD_DEC_TIMEOUT_EN
      push_exp(1'b1, 2'b11, 5'h00);
      send_byte(8'h10, a);
      send_byte(8'h00, a);
      byte_valid = 1'b0;
      n = 0;
      while (n < 2 * TIMEOUT) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (err_stb) break;
      end
      check("timeout_edges", n, TIMEOUT + 1);
      check("timeout_code", {30'd0, err_code}, 32'd3);
      repeat (2) @(negedge clk);
      push_exp(1'b0, 2'b00, 5'h07);
      send_word(32'h1000_0007);
      push_exp(1'b0, 2'b00, 5'h0C);
      send_byte(8'h10, a);
      send_byte(8'h00, a);
      byte_valid = 1'b0;
      repeat (TIMEOUT - 1) @(posedge clk);
      send_byte(8'h00, a);
      send_byte(8'h0C, a);
      byte_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("gap_below_timeout_val", {27'd0, out_val}, 32'h0C);
`else
      push_exp(1'b0, 2'b00, 5'h0A);
      send_byte(8'h10, a);
      send_byte(8'h00, a);
      byte_valid = 1'b0;
      repeat (TIMEOUT + 100) @(posedge clk);
      send_byte(8'h00, a);
      send_byte(8'h0A, a);
      byte_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("long_gap_val", {27'd0, out_val}, 32'h0A);
      check("long_gap_code", {30'd0, err_code}, 32'd1);
`endif

      // Reset in the middle of a word.
      send_byte(8'h10, a);
      send_byte(8'h00, a);
      byte_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_val", {27'd0, out_val}, 32'd0);
      check("midrst_cmd_count", {16'd0, cmd_count}, 32'd0);
      check("midrst_err_code", {30'd0, err_code}, 32'd0);
      check("midrst_out_stb", {31'd0, out_stb}, 32'd0);
      check("midrst_err_stb", {31'd0, err_stb}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      m_val   = '0;
      m_count = 0;
      push_exp(1'b0, 2'b00, 5'h09);
      send_word(32'h1000_0009);
      check("post_rst_val", {27'd0, out_val}, 32'h09);
      check("post_rst_count", {16'd0, cmd_count}, 32'd1);

      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
